// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Three-way arbiter for the single-port program/data memory.
//            One fixed-latency memory transaction per grant, then a one-cycle ack.
// Revision : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int MEM_LATENCY = 1,
    parameter int LOADER_PRIO = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ack,
    input  logic              dat_req,
    input  logic              dat_we,
    input  logic [ADDR_W-1:0] dat_addr,
    input  logic [DATA_W-1:0] dat_wdata,
    output logic              dat_ack,
    input  logic              fet_req,
    input  logic [ADDR_W-1:0] fet_addr,
    output logic              fet_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [1:0]        gnt_id,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [1:0]  r_last;
    logic        r_we;

    logic [3:0]        w_req;
    logic              w_any;
    logic [1:0]        w_win;
    logic              w_found;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

    // k-th candidate in round-robin order, starting just after 'last'
    function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [1:0] k);
        logic [2:0] s;
        s = {1'b0, last} + 3'd1 + {1'b0, k};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    assign w_req = {1'b0, fet_req, dat_req, ld_req};
    assign w_any = |w_req;

    always_comb begin
        w_win   = 2'd0;
        w_found = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (!w_found && w_req[rr_pick(r_last, 2'(k))]) begin
                w_win   = rr_pick(r_last, 2'(k));
                w_found = 1'b1;
            end
        end
        if (LOADER_PRIO != 0 && ld_req) begin
            w_win = 2'd0;
        end
    end

    always_comb begin
        w_we    = 1'b0;
        w_addr  = fet_addr;
        w_wdata = '0;
        case (w_win)
            2'd0: begin
                w_we    = ld_we;
                w_addr  = ld_addr;
                w_wdata = ld_wdata;
            end
            2'd1: begin
                w_we    = dat_we;
                w_addr  = dat_addr;
                w_wdata = dat_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_last    <= 2'd2;
            r_we      <= 1'b0;
            ld_ack    <= 1'b0;
            dat_ack   <= 1'b0;
            fet_ack   <= 1'b0;
            rdata     <= '0;
            busy      <= 1'b0;
            gnt_id    <= 2'd3;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            ld_ack  <= 1'b0;
            dat_ack <= 1'b0;
            fet_ack <= 1'b0;
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        gnt_id    <= w_win;
                        mem_addr  <= w_addr;
                        mem_wdata <= w_wdata;
                        r_we      <= w_we;
                        mem_en    <= 1'b1;
                        mem_we    <= w_we;
                        busy      <= 1'b1;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= 4'(MEM_LATENCY);
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    // memory data is valid exactly in the last wait cycle
                    if (r_cnt == 4'd1) begin
                        if (!r_we) begin
                            rdata <= mem_rdata;
                        end
                        case (gnt_id)
                            2'd0:    ld_ack  <= 1'b1;
                            2'd1:    dat_ack <= 1'b1;
                            2'd2:    fet_ack <= 1'b1;
                            default: ;
                        endcase
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    busy    <= 1'b0;
                    r_last  <= gnt_id;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
